// File: rtl/pic_pkg.sv
// Shared PIC definitions: cascade FSM state type, default CAS width and
// mode encodings used by the cascade controller.
package pic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACK1,
      GAP,
      ACK2
   } cas_state_t;

   localparam int unsigned CAS_W_DEF = 3;

   // Pin-level encodings of ICW1.SNGL and SP/EN that select master behaviour
   localparam logic SNGL_MODE = 1'b1;
   localparam logic SP_MASTER = 1'b1;

endpackage

// File: rtl/cascade_ctrl_inta_edge.sv
// INTA edge detector: registered copy of the synchronised inta_n plus
// single-cycle fall/rise pulses for the cascade sequencer.
module inta_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic inta_n,
   output logic fall,
   output logic rise
);

   logic prev;

   // Reset to the inactive level so a released reset never looks like an edge
   always_ff @(posedge clk) begin
      if (!rst_n) prev <= 1'b1;
      else        prev <= inta_n;
   end

   assign fall = prev & ~inta_n;
   assign rise = ~prev & inta_n;

endmodule

// File: rtl/cascade_ctrl.sv
// Clocked cascade controller: INTA-sequence FSM driving CAS pins (master)
// or matching the CAS ID (slave). Optional GAP timeout: CASCADE_TIMEOUT_EN.
module cascade_ctrl
   import pic_pkg::*;
#(
   parameter int unsigned CAS_W   = CAS_W_DEF,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sngl,
   input  logic                  sp_en,
   input  logic [2**CAS_W-1:0]   icw3,
   input  logic                  inta_n,
   input  logic [CAS_W-1:0]      irq_id,
   input  logic                  irq_valid,
   input  logic [CAS_W-1:0]      cas_in,
   output logic [CAS_W-1:0]      cas_out,
   output logic                  cas_oe,
   output logic                  master,
   output logic                  vec_en,
   output logic                  seq_done,
   output logic                  seq_abort
);

   logic             fall;
   logic             rise;
   cas_state_t       state;
   logic [CAS_W-1:0] sel;
   logic             hit;
   logic [1:0]       mode_q;
   logic             is_master;
   logic             mode_chg;
   logic             m_hit;
   logic             tmo;

   inta_edge u_inta_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .inta_n (inta_n),
      .fall   (fall),
      .rise   (rise)
   );

   assign is_master = (sngl == SNGL_MODE) | (sp_en == SP_MASTER);
   assign mode_chg  = ({sngl, sp_en} != mode_q);
   assign m_hit     = irq_valid & icw3[irq_id] & ~sngl;

`ifdef CASCADE_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;

   // Counter only runs on cycles that stay in GAP; any exit clears it
   always_ff @(posedge clk) begin
      if (!rst_n || state != GAP || fall || mode_chg || tmo) tmo_cnt <= '0;
      else                                                     tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo = (state == GAP) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel       <= '0;
         hit       <= 1'b0;
         mode_q    <= '0;
         master    <= 1'b0;
         cas_out   <= '0;
         cas_oe    <= 1'b0;
         vec_en    <= 1'b0;
         seq_done  <= 1'b0;
         seq_abort <= 1'b0;
      end else begin
         master    <= is_master;
         mode_q    <= {sngl, sp_en};
         seq_done  <= 1'b0;
         seq_abort <= 1'b0;
         if (mode_chg) begin
            state   <= IDLE;
            hit     <= 1'b0;
            cas_out <= '0;
            cas_oe  <= 1'b0;
            vec_en  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: if (fall) begin
                  state <= ACK1;
                  if (is_master) begin
                     sel     <= irq_id;
                     hit     <= m_hit;
                     cas_oe  <= m_hit;
                     cas_out <= m_hit ? irq_id : '0;
                  end else begin
                     sel <= icw3[CAS_W-1:0];
                     hit <= 1'b0;
                  end
               end
               ACK1: if (rise) begin
                  state <= GAP;
                  if (!is_master) hit <= (cas_in == sel);
               end
               GAP: if (fall) begin
                  state  <= ACK2;
                  vec_en <= is_master ? ~hit : hit;
               end else if (tmo) begin
                  state     <= IDLE;
                  seq_abort <= 1'b1;
                  hit       <= 1'b0;
                  cas_out   <= '0;
                  cas_oe    <= 1'b0;
               end
               ACK2: if (rise) begin
                  state    <= IDLE;
                  seq_done <= 1'b1;
                  hit      <= 1'b0;
                  cas_out  <= '0;
                  cas_oe   <= 1'b0;
                  vec_en   <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cascade_ctrl.sv
// Self-checking bench for cascade_ctrl: directed and randomized INTA
// sequences checked against expectations derived from the mode rules.
module tb_cascade_ctrl;

`ifdef CASCADE_TIMEOUT_EN
   localparam int unsigned TMO = 8;
`else
   localparam int unsigned TMO = 64;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sngl;
   logic       sp_en;
   logic [7:0] icw3;
   logic       inta_n;
   logic [2:0] irq_id;
   logic       irq_valid;
   logic [2:0] cas_in;
   logic [2:0] cas_out;
   logic       cas_oe;
   logic       master;
   logic       vec_en;
   logic       seq_done;
   logic       seq_abort;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   cascade_ctrl #(.CAS_W(3), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sngl      (sngl),
      .sp_en     (sp_en),
      .icw3      (icw3),
      .inta_n    (inta_n),
      .irq_id    (irq_id),
      .irq_valid (irq_valid),
      .cas_in    (cas_in),
      .cas_out   (cas_out),
      .cas_oe    (cas_oe),
      .master    (master),
      .vec_en    (vec_en),
      .seq_done  (seq_done),
      .seq_abort (seq_abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic set_cfg(input logic s, input logic spe, input logic [7:0] i3,
                          input logic [2:0] id, input logic v, input logic [2:0] ci);
      @(negedge clk);
      sngl = s; sp_en = spe; icw3 = i3; irq_id = id; irq_valid = v; cas_in = ci;
      repeat (3) @(negedge clk);
   endtask

   // One full two-pulse INTA sequence; expectations follow the mode rules
   task automatic run_seq(input logic s, input logic spe, input logic [7:0] i3,
                          input logic [2:0] id, input logic v, input logic [2:0] ci,
                          input int unsigned w1, input int unsigned gp, input int unsigned w2);
      logic       em, eoe, evec;
      logic [2:0] eout;
      set_cfg(s, spe, i3, id, v, ci);
      em = s | spe;
      if (em) begin
         eoe  = v && i3[id] && !s;
         eout = eoe ? id : 3'd0;
         evec = !eoe;
      end else begin
         eoe  = 1'b0;
         eout = 3'd0;
         evec = (ci == i3[2:0]);
      end
      check("master", master, em);
      check("idle_oe", cas_oe, 0);
      inta_n = 1'b0;
      for (int k = 0; k < int'(w1); k++) begin
         @(negedge clk);
         if (k == 0) begin
            irq_id    = 3'($urandom);
            irq_valid = 1'($urandom);
         end
         check("ack1_oe", cas_oe, eoe);
         check("ack1_out", cas_out, eout);
         check("ack1_vec", vec_en, 0);
      end
      inta_n = 1'b1;
      for (int k = 0; k < int'(gp); k++) begin
         @(negedge clk);
         if (k == 0) cas_in = 3'($urandom);
         check("gap_oe", cas_oe, eoe);
         check("gap_vec", vec_en, 0);
      end
      inta_n = 1'b0;
      for (int k = 0; k < int'(w2); k++) begin
         @(negedge clk);
         check("ack2_oe", cas_oe, eoe);
         check("ack2_out", cas_out, eout);
         check("ack2_vec", vec_en, evec);
         check("ack2_done", seq_done, 0);
      end
      inta_n = 1'b1;
      @(negedge clk);
      check("done_pulse", seq_done, 1);
      check("done_oe", cas_oe, 0);
      check("done_vec", vec_en, 0);
      check("done_abort", seq_abort, 0);
      @(negedge clk);
      check("done_clear", seq_done, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; sngl = 1'b0; sp_en = 1'b1; icw3 = '0; inta_n = 1'b1;
      irq_id = '0; irq_valid = 1'b0; cas_in = '0;
      repeat (2) @(negedge clk);
      check("rst_master", master, 0);
      check("rst_oe", cas_oe, 0);
      check("rst_out", cas_out, 0);
      check("rst_vec", vec_en, 0);
      check("rst_done", seq_done, 0);
      check("rst_abort", seq_abort, 0);
      rst_n = 1'b1;

      run_seq(1'b0, 1'b1, 8'b0000_0100, 3'd2, 1'b1, 3'd0, 2, 2, 2);
      run_seq(1'b0, 1'b1, 8'h00, 3'd5, 1'b1, 3'd0, 3, 1, 2);
      run_seq(1'b0, 1'b0, 8'h03, 3'd1, 1'b1, 3'd3, 2, 3, 2);
      run_seq(1'b0, 1'b0, 8'h03, 3'd1, 1'b1, 3'd6, 2, 3, 2);
      run_seq(1'b1, 1'b0, 8'hFF, 3'd7, 1'b1, 3'd0, 2, 2, 1);
      run_seq(1'b0, 1'b1, 8'hFF, 3'd4, 1'b0, 3'd0, 1, 1, 1);

      for (int i = 0; i < 40; i++) begin
         logic       s, spe, v;
         logic [7:0] i3;
         logic [2:0] ci;
         s   = ($urandom_range(0, 3) == 0);
         spe = 1'($urandom_range(0, 1));
         i3  = 8'($urandom);
         v   = ($urandom_range(0, 3) != 0);
         ci  = $urandom_range(0, 1) ? i3[2:0] : 3'($urandom);
         run_seq(s, spe, i3, 3'($urandom), v, ci,
                 $urandom_range(1, 4), $urandom_range(1, 5), $urandom_range(1, 4));
      end

      // Reset in GAP of a master hit sequence
      set_cfg(1'b0, 1'b1, 8'b0000_0100, 3'd2, 1'b1, 3'd0);
      inta_n = 1'b0;
      repeat (2) @(negedge clk);
      inta_n = 1'b1;
      repeat (2) @(negedge clk);
      check("pre_rst_oe", cas_oe, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_oe", cas_oe, 0);
      check("midrst_out", cas_out, 0);
      check("midrst_master", master, 0);
      rst_n = 1'b1;
      run_seq(1'b0, 1'b1, 8'b0000_0100, 3'd2, 1'b1, 3'd0, 2, 2, 2);

      // Mode change in GAP drops everything without seq_done
      set_cfg(1'b0, 1'b1, 8'b0010_0000, 3'd5, 1'b1, 3'd0);
      inta_n = 1'b0;
      repeat (2) @(negedge clk);
      inta_n = 1'b1;
      @(negedge clk);
      check("pre_mc_oe", cas_oe, 1);
      sp_en = 1'b0;
      @(negedge clk);
      check("mc_oe", cas_oe, 0);
      check("mc_out", cas_out, 0);
      check("mc_done", seq_done, 0);
      @(negedge clk);
      check("mc_done2", seq_done, 0);
      check("mc_vec", vec_en, 0);
      run_seq(1'b0, 1'b1, 8'b0010_0000, 3'd5, 1'b1, 3'd0, 2, 2, 2);

`ifdef CASCADE_TIMEOUT_EN
      set_cfg(1'b0, 1'b1, 8'b0000_0100, 3'd2, 1'b1, 3'd0);
      inta_n = 1'b0;
      repeat (2) @(negedge clk);
      inta_n = 1'b1;
      for (int k = 0; k < int'(TMO); k++) begin
         @(negedge clk);
         check("tmo_wait_abort", seq_abort, 0);
         check("tmo_wait_oe", cas_oe, 1);
      end
      @(negedge clk);
      check("tmo_abort", seq_abort, 1);
      check("tmo_oe", cas_oe, 0);
      check("tmo_vec", vec_en, 0);
      @(negedge clk);
      check("tmo_abort_clr", seq_abort, 0);
      run_seq(1'b0, 1'b1, 8'b0000_0100, 3'd2, 1'b1, 3'd0, 2, 2, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
